alu_seq_divider: RTL

//  Multi-cycle signed divide/modulo unit for the ALU's DIV and MOD ops; replaces the single-cycle combinational
//  d0 / d1 and d0 % d1 path. The issuing side pulses start with operands; this block iterates and returns the

---
 rtl/alu_seq_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_divider.sv
// Multi-cycle signed divide/modulo unit: restoring division on magnitudes, one quotient bit per cycle,
// then sign fix-up. Quotient truncates toward zero, remainder takes the sign of the dividend.
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DZ   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             mod_q, mod_d;
  logic             sn0_q, sn0_d;
  logic             sn1_q, sn1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dbz_q, dbz_d;

  // The shifted partial remainder needs WIDTH+1 bits; after a restoring step it is
  // always below |d1| and fits back in WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    // quot_q starts as |d0|; dividend bits leave at the MSB while quotient bits enter at the LSB.
    rem_sh  = {rem_q, quot_q[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
    q_fix   = (sn0_q ^ sn1_q) ? -quot_q : quot_q;
    r_fix   = sn0_q ? -rem_q : rem_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    mod_d   = mod_q;
    sn0_d   = sn0_q;
    sn1_d   = sn1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mod_d   = op_mod;
          sn0_d   = d0[WIDTH-1];
          sn1_d   = d1[WIDTH-1];
          quot_d  = d0[WIDTH-1] ? -d0 : d0;
          dvs_d   = d1[WIDTH-1] ? -d1 : d1;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (d1 == '0) ? S_DZ : S_CALC;
        end
      end
      S_CALC: begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d  = rem_sub;
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        dout_d  = mod_q ? r_fix : q_fix;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_DZ: begin
        dout_d  = '0;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      sn0_q   <= 1'b0;
      sn1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      sn0_q   <= sn0_d;
      sn1_q   <= sn1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dout        = dout_q;
  assign div_by_zero = dbz_q;

endmodule
